// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: turns datapath address/data-slot pulses into register-bus
// reads and writes, serving the SPI mode register locally and reporting sticky error status.
module spi_txn_ctrl #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [15:0] MODE_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        address_ready,
    input  logic        data_ready,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [1:0]  spi_mode,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    input  logic        bus_err,
    output logic [3:0]  status
);

    typedef enum logic [2:0] {IDLE, RD_REQ, WAIT_DATA, WR_REQ, DRAIN} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] ptr_q;
    logic        dir_q;
    logic [15:0] rdata_q;
    logic [15:0] bus_wdata_q;
    logic [1:0]  mode_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [7:0]  tmo_cnt_q;
    logic        err_q;
    logic        tmo_q;
    logic        ovr_q;
    logic        cs_meta_q;
    logic        cs_sync_q;
    logic        cs_prev_q;
    logic        armed_q;

    logic        frame_end;
    logic        in_req;
    logic        local_hit;
    logic        tmo_hit;
    logic        accept;
    logic [15:0] ptr_inc;
    logic        addr_unused;

    assign frame_end   = cs_sync_q & ~cs_prev_q;
    assign in_req      = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign local_hit   = (ptr_q == MODE_ADDR);
    assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
    // Leaving reset mid-frame: wait for a frame boundary or a low chip select first.
    assign accept      = address_ready && !frame_end && (armed_q || !cs_sync_q);
    assign ptr_inc     = ptr_q + 16'd1;
    assign addr_unused = ^addr[18:16];

    // NOTE: state and outputs use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            dir_q       <= 1'b0;
            rdata_q     <= '0;
            bus_wdata_q <= '0;
            mode_q      <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            ovr_q       <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            if (frame_end) armed_q <= 1'b1;
            if (in_req && data_ready) ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ptr_q <= addr[15:0];
                        dir_q <= addr[19];
                        err_q <= 1'b0;
                        tmo_q <= 1'b0;
                        ovr_q <= 1'b0;
                        if (addr[19]) begin
                            state_q <= WAIT_DATA;
                        end else begin
                            state_q   <= RD_REQ;
                            bus_req_q <= (addr[15:0] != MODE_ADDR);
                            bus_we_q  <= 1'b0;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (frame_end) begin
                        state_q <= IDLE;
                    end else if (data_ready) begin
                        state_q   <= dir_q ? WR_REQ : RD_REQ;
                        bus_req_q <= !local_hit;
                        bus_we_q  <= dir_q && !local_hit;
                        if (dir_q) bus_wdata_q <= wdata;
                    end
                end

                RD_REQ, WR_REQ: begin
                    if (local_hit || bus_ack || tmo_hit) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= frame_end ? IDLE : WAIT_DATA;
                        if (local_hit) begin
                            ptr_q <= ptr_inc;
                            if (dir_q) mode_q  <= bus_wdata_q[1:0];
                            else       rdata_q <= {14'b0, mode_q};
                        end else if (bus_ack) begin
                            ptr_q <= ptr_inc;
                            if (!dir_q)  rdata_q <= bus_rdata;
                            if (bus_err) err_q   <= 1'b1;
                        end else begin
                            tmo_q <= 1'b1;
                            if (!dir_q) rdata_q <= 16'hDEAD;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        if (frame_end) state_q <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The frame is gone: finish the bus handshake but discard its result.
                    if (bus_ack || tmo_hit) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= IDLE;
                        if (bus_ack) begin
                            if (bus_err) err_q <= 1'b1;
                        end else begin
                            tmo_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign spi_mode  = mode_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = ptr_q;
    assign bus_wdata = bus_wdata_q;
    assign status    = {ovr_q, tmo_q, err_q, state_q != IDLE};

endmodule
